// File: rtl/data_ram_banked.sv
// data_ram_banked: byte-lane data RAM with valid/ready request, programmable wait states and one-cycle ack.
// Define DATA_RAM_MISALIGN_EN to reject misaligned/non-contiguous lane selects with err.
module data_ram_banked #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int ADDR_W     = 32,
    parameter int WAIT       = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W/8-1:0]   sel,
    input  logic [DATA_W-1:0]     data_i,
    output logic                  ready,
    output logic                  ack,
    output logic [DATA_W-1:0]     data_o,
    output logic                  err
);
    localparam int NB    = DATA_W / 8;
    localparam int L     = $clog2(NB);
    localparam int DEPTH = 2 ** DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q;
    logic                  we_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [NB-1:0]         sel_q, sel_eff;
    logic [DATA_W-1:0]     data_q, rd;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  acc, err_d, unused_addr;

    assign idx         = addr_q[L+DEPTH_LOG2-1:L];
    assign acc         = state_q == BUSY && cnt_q == 4'd0;
    assign unused_addr = ^{addr_q[ADDR_W-1:L+DEPTH_LOG2], addr_q[L-1:0]};

`ifdef DATA_RAM_MISALIGN_EN
    // Legal: a naturally aligned run of 1, 2, 4 ... NB lanes starting at the byte offset.
    function automatic logic legal(input logic [L-1:0] off, input logic [NB-1:0] s);
        logic        ok;
        int          o;
        logic [63:0] m;
        ok = 1'b0;
        o  = int'(off);
        for (int n = 1; n <= NB; n = n * 2) begin
            m = ((64'd1 << n) - 64'd1) << o;
            if (o % n == 0 && s == m[NB-1:0]) ok = 1'b1;
        end
        return ok;
    endfunction

    assign err_d   = !legal(addr_q[L-1:0], sel_q);
    assign sel_eff = err_d ? '0 : sel_q;
`else
    assign err_d   = 1'b0;
    assign sel_eff = sel_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q == IDLE ? (ce ? BUSY : IDLE) :
                  state_q == BUSY ? (cnt_q == 4'd0 ? RESP : BUSY) : IDLE;
    end

    always_comb begin
        ready = state_q == IDLE;
        ack   = state_q == RESP;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= 4'd0;
            we_q   <= 1'b0;
            addr_q <= '0;
            sel_q  <= '0;
            data_q <= '0;
            data_o <= '0;
            err    <= 1'b0;
        end else begin
            if (state_q == IDLE && ce) begin
                we_q   <= we;
                addr_q <= addr;
                sel_q  <= sel;
                data_q <= data_i;
                cnt_q  <= 4'(WAIT);
            end else if (state_q == BUSY && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (acc) begin
                data_o <= we_q ? '0 : rd;
                err    <= err_d;
            end
        end
    end

    // Lane arrays are not reset; the FSM's async reset alone guarantees no write after an abort.
    genvar i;
    for (i = 0; i < NB; i++) begin : g_lane
        logic [7:0] mem [DEPTH];
        always_ff @(posedge clk) begin
            if (acc && we_q && sel_eff[i]) mem[idx] <= data_q[8*i +: 8];
        end
        assign rd[8*i +: 8] = sel_eff[i] ? mem[idx] : 8'h00;
    end
endmodule

// File: tb/tb_data_ram_banked.sv
// tb_data_ram_banked: directed and random checks of data_ram_banked against a byte-addressed reference model.
module tb_data_ram_banked;
    localparam int W = 1;

    logic        clk = 1'b0, rst = 1'b1, ce = 1'b0, we = 1'b0, ce_h = 1'b0;
    logic [31:0] addr = '0, data_i = '0, data_o, d0, d3, q;
    logic [3:0]  sel = '0;
    logic        ready, ack, err, r0, a0, e0, r3, a3, e3;
    int          errors = 0, checks = 0;
    logic [7:0]  mm [int];

    always #5 clk = ~clk;

    data_ram_banked #(.DATA_W(32), .DEPTH_LOG2(10), .ADDR_W(32), .WAIT(W)) dut (
        .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .sel(sel), .data_i(data_i),
        .ready(ready), .ack(ack), .data_o(data_o), .err(err));

    data_ram_banked #(.DATA_W(32), .DEPTH_LOG2(10), .ADDR_W(32), .WAIT(0)) u0 (
        .clk(clk), .rst(rst), .ce(ce_h), .we(1'b0), .addr(32'h0), .sel(4'h0), .data_i(32'h0),
        .ready(r0), .ack(a0), .data_o(d0), .err(e0));

    data_ram_banked #(.DATA_W(32), .DEPTH_LOG2(10), .ADDR_W(32), .WAIT(3)) u3 (
        .clk(clk), .rst(rst), .ce(ce_h), .we(1'b0), .addr(32'h0), .sel(4'h0), .data_i(32'h0),
        .ready(r3), .ack(a3), .data_o(d3), .err(e3));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic legal(input logic [31:0] a, input logic [3:0] s);
`ifdef DATA_RAM_MISALIGN_EN
        int n, off;
        n   = $countones(s);
        off = int'(a[1:0]);
        if (!(n == 1 || n == 2 || n == 4)) return 1'b0;
        return off % n == 0 && s == 4'(((1 << n) - 1) << off);
`else
        return 1'b1;
`endif
    endfunction

    // Starts at a negedge with the DUT idle; returns at the negedge after the ack cycle.
    task automatic op(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                      output logic [31:0] res);
        int n, wd;
        logic ok;
        logic [31:0] exp;
        ok  = legal(a, s);
        wd  = int'((a >> 2) & 32'h3FF);
        exp = '0;
        for (int i = 0; i < 4; i++) begin
            if (!w && ok && s[i]) exp[8*i +: 8] = mm[wd*4+i];
            if (w && ok && s[i]) mm[wd*4+i] = d[8*i +: 8];
        end
        ce = 1'b1; we = w; addr = a; sel = s; data_i = d;
        @(posedge clk);
        #1;
        ce = 1'b0; we = 1'($urandom); addr = $urandom; sel = 4'($urandom); data_i = $urandom;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            chk("ready_busy", 32'(ready), 32'd0);
        end while (!ack && n < 20);
        chk("latency", n, W + 2);
        chk("data_o", data_o, exp);
        chk("err", 32'(err), 32'(!ok));
        res = data_o;
        @(negedge clk);
        chk("ready_idle", 32'(ready), 32'd1);
        chk("ack_one_cycle", 32'(ack), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int last0, last3, rc3, seen;
        logic [31:0] a;
        #1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_data_o", data_o, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ce_h = 1'b1;

        // ce held high: ack period WAIT+3, ready high once per period and low during ack
        last0 = -1; last3 = -1; rc3 = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (r3) rc3++;
            if (a0) begin
                if (last0 >= 0) chk("gap_wait0", i - last0, 3);
                chk("ready_ack_wait0", 32'(r0), 32'd0);
                last0 = i;
            end
            if (a3) begin
                if (last3 >= 0) begin
                    chk("gap_wait3", i - last3, 6);
                    chk("ready_cnt_wait3", rc3, 1);
                end
                chk("ready_ack_wait3", 32'(r3), 32'd0);
                chk("sel0_load_wait3", d3, 32'd0);
                last3 = i;
                rc3 = 0;
            end
        end
        chk("saw_ack_wait0", 32'(last0 >= 0), 32'd1);
        chk("saw_ack_wait3", 32'(last3 >= 0), 32'd1);

        op(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, q);
        op(1'b0, 32'h10, 4'hF, 32'h0, q);
        chk("roundtrip", q, 32'hDEADBEEF);

        op(1'b1, 32'h20, 4'hF, 32'h11223344, q);
        op(1'b1, 32'h20, 4'b0100, 32'h00AA0000, q);
        op(1'b0, 32'h20, 4'hF, 32'h0, q);
        chk("lane_merge", q, 32'h11AA3344);
        op(1'b0, 32'h20, 4'b0011, 32'h0, q);
        chk("lane_zero_fill", q, 32'h00003344);
        op(1'b0, 32'h20, 4'h0, 32'h0, q);
        chk("sel0_load", q, 32'h0);

        // async reset in the middle of a cycle while ack and data_o are live
        ce = 1'b1; we = 1'b0; addr = 32'h10; sel = 4'hF;
        @(posedge clk);
        #1 ce = 1'b0;
        repeat (W + 2) @(negedge clk);
        chk("pre_rst_ack", 32'(ack), 32'd1);
        chk("pre_rst_data", data_o, 32'hDEADBEEF);
        #2 rst = 1'b1;
        #1;
        chk("async_ready", 32'(ready), 32'd1);
        chk("async_ack", 32'(ack), 32'd0);
        chk("async_data_o", data_o, 32'd0);
        chk("async_err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        op(1'b1, 32'h40, 4'hF, 32'h55667788, q);
        ce = 1'b1; we = 1'b1; addr = 32'h40; sel = 4'hF; data_i = 32'hCAFEF00D;
        @(posedge clk);
        #1 ce = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack) seen++;
        end
        chk("abort_no_ack", seen, 0);
        op(1'b0, 32'h40, 4'hF, 32'h0, q);
        chk("abort_dropped", q, 32'h55667788);

`ifdef DATA_RAM_MISALIGN_EN
        op(1'b1, 32'h30, 4'hF, 32'h01020304, q);
        op(1'b1, 32'h31, 4'b0110, 32'hFFFFFFFF, q);
        op(1'b0, 32'h30, 4'hF, 32'h0, q);
        chk("misalign_unchanged", q, 32'h01020304);
        op(1'b1, 32'h32, 4'b1100, 32'hAABB0000, q);
        op(1'b0, 32'h30, 4'hF, 32'h0, q);
        chk("aligned_half", q, 32'hAABB0304);
`endif

        for (int k = 0; k < 8; k++) op(1'b1, 32'((64 + k) << 2), 4'hF, $urandom, q);
        for (int k = 0; k < 40; k++) begin
            a = ((32'($urandom) & 32'hFFFFF) << 12) | (32'(64 + $urandom_range(0, 7)) << 2)
                | 32'($urandom_range(0, 3));
            op(1'($urandom), a, 4'($urandom), $urandom, q);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
